// File: rtl/instr_sequencer.sv
// instr_sequencer: major-state controller for the PDP-8 instruction cycle.
// Walks FETCH -> DECODE -> (DEFER) -> EXEC/EXEC2/JUMP -> NEXT, drives the
// program-counter strobes and handshakes each memory access on MEMDONE.
// NEXT is not a state of its own: it is a registered sub-step flag that
// rides on the FETCH encoding, so it reports STATE=2.
module instr_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       STOP,
    input  logic       LOADADDR,
    input  logic [2:0] OPCODE,
    input  logic       IND,
    input  logic       SKIP,
    input  logic       MEMDONE,
    output logic       PC_CLR,
    output logic       PC_LD,
    output logic [1:0] PC_SRC,
    output logic       PC_INC,
    output logic       PC_LATCH1,
    output logic       PC_LATCH2,
    output logic       ADDR_SEL,
    output logic       MEMREQ,
    output logic       MEMWR,
    output logic       IR_LD,
    output logic       RUNNING,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_HALT   = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_DEFER  = 3'd4,
        S_EXEC   = 3'd5,
        S_EXEC2  = 3'd6,
        S_JUMP   = 3'd7
    } state_t;

    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;

    state_t r_state;
    logic   r_next;       // NEXT sub-step active (r_state holds S_FETCH)
    logic   r_stop;       // halt requested, honoured at the end of the instruction
    logic   r_skip;       // skip condition captured during the instruction
    logic   r_exec_wait;  // already spent at least one cycle in EXEC

    state_t w_state_nxt;
    logic   w_next_nxt;
    logic   w_stop_nxt;
    logic   w_skip_nxt;
    logic   w_exec_wait_nxt;

    // State register and control flags; synchronous reset to CLEAR.
    always_ff @(posedge CLK) begin
        // NOTE: every register here uses <= so all flops sample the same
        // pre-edge values; a blocking = would leak updates between them.
        if (RESET) begin
            r_state     <= S_CLEAR;
            r_next      <= 1'b0;
            r_stop      <= 1'b0;
            r_skip      <= 1'b0;
            r_exec_wait <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_next      <= w_next_nxt;
            r_stop      <= w_stop_nxt;
            r_skip      <= w_skip_nxt;
            r_exec_wait <= w_exec_wait_nxt;
        end
    end

    // Next-state, flag updates and strobe decode from state and MEMDONE.
    always_comb begin
        // NOTE: every output and next value gets a default before the case;
        // any path that skipped an assignment would otherwise infer a latch.
        w_state_nxt     = r_state;
        w_next_nxt      = 1'b0;
        w_stop_nxt      = r_stop;
        w_skip_nxt      = r_skip;
        w_exec_wait_nxt = 1'b0;
        PC_CLR          = 1'b0;
        PC_LD           = 1'b0;
        PC_SRC          = 2'b00;
        PC_INC          = 1'b0;
        PC_LATCH1       = 1'b0;
        PC_LATCH2       = 1'b0;
        ADDR_SEL        = 1'b0;
        MEMREQ          = 1'b0;
        MEMWR           = 1'b0;
        IR_LD           = 1'b0;
        STATE           = r_state;
        RUNNING         = (r_state != S_CLEAR) && (r_state != S_HALT);

        if (RUNNING && STOP) begin
            w_stop_nxt = 1'b1;
        end

        if (r_next) begin
            // End of instruction: apply a pending skip, then halt or refetch.
            PC_INC     = r_skip;
            w_skip_nxt = 1'b0;
            if (r_stop) begin
                w_state_nxt = S_HALT;
                w_stop_nxt  = 1'b0;
            end else begin
                w_state_nxt = S_FETCH;
            end
        end else begin
            case (r_state)
                S_CLEAR: begin
                    PC_CLR      = 1'b1;
                    w_state_nxt = S_HALT;
                end
                S_HALT: begin
                    if (LOADADDR) begin
                        PC_LD  = 1'b1;
                        PC_SRC = 2'b00;
                    end else if (START) begin
                        w_state_nxt = S_FETCH;
                        w_stop_nxt  = 1'b0;
                    end
                end
                S_FETCH: begin
                    MEMREQ    = 1'b1;
                    PC_LATCH1 = 1'b1;
                    if (MEMDONE) begin
                        IR_LD       = 1'b1;
                        PC_INC      = 1'b1;
                        w_state_nxt = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (IND && (OPCODE <= OP_JMP)) begin
                        w_state_nxt = S_DEFER;
                    end else if (OPCODE == OP_JMP) begin
                        w_state_nxt = S_JUMP;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
                end
                S_DEFER: begin
                    MEMREQ   = 1'b1;
                    ADDR_SEL = 1'b1;
                    if (MEMDONE) begin
                        w_state_nxt = (OPCODE == OP_JMP) ? S_JUMP : S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (OPCODE <= OP_JMS) begin
                        // Memory-reference operate phase: one read or write at EA.
                        MEMREQ    = 1'b1;
                        ADDR_SEL  = 1'b1;
                        MEMWR     = (OPCODE == OP_DCA) || (OPCODE == OP_JMS);
                        PC_LATCH2 = (OPCODE == OP_JMS) && !r_exec_wait;
                        if (MEMDONE) begin
                            if (OPCODE == OP_ISZ) begin
                                w_state_nxt = S_EXEC2;
                            end else if (OPCODE == OP_JMS) begin
                                w_state_nxt = S_JUMP;
                            end else begin
                                w_state_nxt = S_FETCH;
                                w_next_nxt  = 1'b1;
                            end
                        end else begin
                            w_exec_wait_nxt = 1'b1;
                        end
                    end else begin
                        // IOT / OPR: no memory traffic, just capture the skip.
                        w_skip_nxt  = SKIP;
                        w_state_nxt = S_FETCH;
                        w_next_nxt  = 1'b1;
                    end
                end
                S_EXEC2: begin
                    MEMREQ   = 1'b1;
                    MEMWR    = 1'b1;
                    ADDR_SEL = 1'b1;
                    if (MEMDONE) begin
                        w_skip_nxt  = SKIP;
                        w_state_nxt = S_FETCH;
                        w_next_nxt  = 1'b1;
                    end
                end
                S_JUMP: begin
                    PC_LD       = 1'b1;
                    PC_SRC      = (OPCODE == OP_JMS) ? 2'b10 : 2'b01;
                    w_state_nxt = S_FETCH;
                    w_next_nxt  = 1'b1;
                end
                default: begin
                    w_state_nxt = S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer. A driver expands each instruction into its
// phases (fetch, decode, defer, operate, jump, next) from the instruction-cycle
// rules, applies the per-cycle inputs and queues the expected outputs; a
// monitor pops one expectation per cycle and compares it with the DUT.
module tb_instr_sequencer;

    logic       CLK = 1'b0;
    logic       RESET, START, STOP, LOADADDR, IND, SKIP, MEMDONE;
    logic [2:0] OPCODE;
    logic       PC_CLR, PC_LD, PC_INC, PC_LATCH1, PC_LATCH2;
    logic       ADDR_SEL, MEMREQ, MEMWR, IR_LD, RUNNING;
    logic [1:0] PC_SRC;
    logic [2:0] STATE;

    instr_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP),
        .LOADADDR(LOADADDR), .OPCODE(OPCODE), .IND(IND), .SKIP(SKIP),
        .MEMDONE(MEMDONE), .PC_CLR(PC_CLR), .PC_LD(PC_LD), .PC_SRC(PC_SRC),
        .PC_INC(PC_INC), .PC_LATCH1(PC_LATCH1), .PC_LATCH2(PC_LATCH2),
        .ADDR_SEL(ADDR_SEL), .MEMREQ(MEMREQ), .MEMWR(MEMWR), .IR_LD(IR_LD),
        .RUNNING(RUNNING), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] state;
        logic       running;
        logic       pc_clr;
        logic       pc_ld;
        logic [1:0] pc_src;
        logic       pc_inc;
        logic       pc_latch1;
        logic       pc_latch2;
        logic       addr_sel;
        logic       memreq;
        logic       memwr;
        logic       ir_ld;
    } obs_t;

    typedef struct packed {
        logic       reset;
        logic       start;
        logic       stop;
        logic       loadaddr;
        logic [2:0] opcode;
        logic       ind;
        logic       skip;
        logic       memdone;
    } stim_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    // Reference-model state
    bit         m_stop   = 1'b0;
    bit         m_skip   = 1'b0;
    bit         m_halted = 1'b0;
    logic [2:0] cur_op   = 3'd0;
    logic       cur_ind  = 1'b0;
    int         f_skip   = -1;
    bit         rand_stop = 1'b0;

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
                     name, act.state, act, exp.state, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled on the falling edge.
    always @(negedge CLK) begin : monitor
        obs_t  act;
        obs_t  e;
        string t;
        if (exp_q.size() != 0) begin
            act.state     = STATE;
            act.running   = RUNNING;
            act.pc_clr    = PC_CLR;
            act.pc_ld     = PC_LD;
            act.pc_src    = PC_SRC;
            act.pc_inc    = PC_INC;
            act.pc_latch1 = PC_LATCH1;
            act.pc_latch2 = PC_LATCH2;
            act.addr_sel  = ADDR_SEL;
            act.memreq    = MEMREQ;
            act.memwr     = MEMWR;
            act.ir_ld     = IR_LD;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, act, e);
        end
    end

    function automatic obs_t mk(input logic [2:0] st);
        obs_t o;
        o         = '0;
        o.state   = st;
        o.running = (st != 3'd0) && (st != 3'd1);
        o.pc_clr  = (st == 3'd0);
        return o;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.reset    = 1'b0;
        s.start    = 1'($urandom_range(0, 1));
        s.loadaddr = 1'($urandom_range(0, 1));
        s.stop     = rand_stop && ($urandom_range(0, 31) == 0);
        s.opcode   = cur_op;
        s.ind      = cur_ind;
        s.skip     = (f_skip >= 0) ? 1'(f_skip) : 1'($urandom_range(0, 1));
        s.memdone  = 1'($urandom_range(0, 1));
        return s;
    endfunction

    function automatic int pick_wait(input int wfix);
        return (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
    endfunction

    // Apply one cycle of inputs and queue what the outputs must be.
    task automatic drive(input stim_t s, input obs_t e, input string tag);
        @(posedge CLK);
        #1;
        RESET    = s.reset;
        START    = s.start;
        STOP     = s.stop;
        LOADADDR = s.loadaddr;
        OPCODE   = s.opcode;
        IND      = s.ind;
        SKIP     = s.skip;
        MEMDONE  = s.memdone;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (s.stop && e.running) m_stop = 1'b1;
        if (s.reset) begin
            m_stop = 1'b0;
            m_skip = 1'b0;
        end
    endtask

    // One memory access: 'waits' idle cycles, then the MEMDONE cycle.
    task automatic mem_access(input logic [2:0] st, input int waits, input bit wr,
                              input bit asel, input bit l1, input bit l2,
                              input bit fetch, input bit pulse_stop,
                              input string tag, output bit done_skip);
        stim_t s;
        obs_t  e;
        done_skip = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            s           = rnd_stim();
            s.memdone   = (i == waits);
            if (pulse_stop && i == 0) s.stop = 1'b1;
            e           = mk(st);
            e.memreq    = 1'b1;
            e.memwr     = wr;
            e.addr_sel  = asel;
            e.pc_latch1 = l1;
            e.pc_latch2 = l2 && (i == 0);
            if (fetch && i == waits) begin
                e.ir_ld  = 1'b1;
                e.pc_inc = 1'b1;
            end
            drive(s, e, tag);
            done_skip = s.skip;
        end
    endtask

    // Whole instruction from FETCH through NEXT.
    task automatic run_instr(input logic [2:0] op, input logic ind,
                             input int wfix, input bit stop_exec);
        bit    sk;
        bit    halting;
        stim_t s;
        obs_t  e;
        cur_op  = op;
        cur_ind = ind;
        mem_access(3'd2, pick_wait(wfix), 0, 0, 1, 0, 1, 0, "fetch", sk);
        s = rnd_stim();
        drive(s, mk(3'd3), "decode");
        if (ind && op <= 3'd5)
            mem_access(3'd4, pick_wait(wfix), 0, 1, 0, 0, 0, 0, "defer", sk);
        case (op)
            3'd0, 3'd1, 3'd2:
                mem_access(3'd5, pick_wait(wfix), 0, 1, 0, 0, 0, stop_exec, "exec_read", sk);
            3'd3:
                mem_access(3'd5, pick_wait(wfix), 1, 1, 0, 0, 0, stop_exec, "exec_dca", sk);
            3'd4:
                mem_access(3'd5, pick_wait(wfix), 1, 1, 0, 1, 0, stop_exec, "exec_jms", sk);
            3'd6, 3'd7: begin
                s = rnd_stim();
                if (stop_exec) s.stop = 1'b1;
                drive(s, mk(3'd5), "exec_iot_opr");
                m_skip = s.skip;
            end
            default: ;
        endcase
        if (op == 3'd2) begin
            mem_access(3'd6, pick_wait(wfix), 1, 1, 0, 0, 0, 0, "exec2_isz", sk);
            m_skip = sk;
        end
        if (op == 3'd4 || op == 3'd5) begin
            e        = mk(3'd7);
            e.pc_ld  = 1'b1;
            e.pc_src = (op == 3'd4) ? 2'b10 : 2'b01;
            s        = rnd_stim();
            drive(s, e, "jump");
        end
        halting  = m_stop;
        e        = mk(3'd2);
        e.pc_inc = m_skip;
        s        = rnd_stim();
        drive(s, e, "next");
        m_skip = 1'b0;
        if (halting) begin
            m_stop   = 1'b0;
            m_halted = 1'b1;
        end
    endtask

    // Idle in HALT, optionally load the PC, then start.
    task automatic halt_phase(input int n_idle, input bit do_load, input bit force_start);
        stim_t s;
        obs_t  e;
        for (int i = 0; i < n_idle; i++) begin
            s          = rnd_stim();
            s.start    = 1'b0;
            s.loadaddr = 1'b0;
            drive(s, mk(3'd1), "halt_idle");
        end
        if (do_load) begin
            s          = rnd_stim();
            s.loadaddr = 1'b1;
            if (force_start) s.start = 1'b1;
            e          = mk(3'd1);
            e.pc_ld    = 1'b1;
            drive(s, e, "halt_load");
        end
        s          = rnd_stim();
        s.start    = 1'b1;
        s.loadaddr = 1'b0;
        drive(s, mk(3'd1), "halt_start");
        m_stop   = 1'b0;
        m_halted = 1'b0;
    endtask

    initial begin
        stim_t s;
        obs_t  e;
        RESET    = 1'b1;
        START    = 1'b0;
        STOP     = 1'b0;
        LOADADDR = 1'b0;
        OPCODE   = 3'd0;
        IND      = 1'b0;
        SKIP     = 1'b0;
        MEMDONE  = 1'b0;

        // Reset held two cycles, then one CLEAR cycle after release.
        s = rnd_stim();
        s.reset = 1'b1;
        drive(s, mk(3'd0), "reset_hold");
        s = rnd_stim();
        drive(s, mk(3'd0), "reset_release_clear");
        m_halted = 1'b1;

        // LOADADDR beats START in the same cycle; START alone then runs.
        halt_phase(2, 1'b1, 1'b1);

        // Zero-wait JMP direct.
        run_instr(3'd5, 1'b0, 0, 1'b0);
        // ISZ with SKIP high: skip increment in NEXT.
        f_skip = 1;
        run_instr(3'd2, 1'b0, 0, 1'b0);
        f_skip = -1;
        // Indirect JMS with two wait cycles per access.
        run_instr(3'd4, 1'b1, 2, 1'b0);
        // TAD with STOP pulsed in EXEC: halts after NEXT.
        run_instr(3'd1, 1'b0, 0, 1'b1);

        // Restart, then reset during a stalled fetch.
        halt_phase(1, 1'b0, 1'b0);
        cur_op = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++) begin
            s           = rnd_stim();
            s.memdone   = 1'b0;
            s.reset     = (i == 2);
            e           = mk(3'd2);
            e.memreq    = 1'b1;
            e.pc_latch1 = 1'b1;
            drive(s, e, "fetch_wait_reset");
        end
        s = rnd_stim();
        drive(s, mk(3'd0), "post_reset_clear");
        m_halted = 1'b1;

        // Randomized instruction stream with occasional STOP requests.
        rand_stop = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (m_halted)
                halt_phase(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
            run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        @(negedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
